// File: rtl/acc_resp_shim.sv
// rtl/acc_resp_shim.sv - accelerator request spill stage, outstanding cap, response FIFO, store tracking
// Optional ID/underflow checking is enabled by defining ACC_RESP_SHIM_ID_CHECK_EN.
module acc_resp_shim #(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned RespDepth      = 2,
  parameter int unsigned XLEN           = 64,
  parameter int unsigned TransIdBits    = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [31:0]            req_insn_i,
  input  logic [XLEN-1:0]        req_rs1_i,
  input  logic [XLEN-1:0]        req_rs2_i,
  input  logic [2:0]             req_frm_i,
  input  logic [TransIdBits-1:0] req_trans_id_i,
  input  logic                   req_is_load_i,
  input  logic                   req_is_store_i,
  output logic                   acc_req_valid_o,
  input  logic                   acc_req_ready_i,
  output logic [31:0]            acc_req_insn_o,
  output logic [XLEN-1:0]        acc_req_rs1_o,
  output logic [XLEN-1:0]        acc_req_rs2_o,
  output logic [2:0]             acc_req_frm_o,
  output logic [TransIdBits-1:0] acc_req_trans_id_o,
  input  logic                   acc_resp_valid_i,
  output logic                   acc_resp_ready_o,
  input  logic [TransIdBits-1:0] acc_resp_trans_id_i,
  input  logic [XLEN-1:0]        acc_resp_result_i,
  input  logic                   acc_resp_exc_valid_i,
  input  logic [XLEN-1:0]        acc_resp_exc_cause_i,
  input  logic                   acc_load_done_i,
  input  logic                   acc_store_done_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [TransIdBits-1:0] resp_trans_id_o,
  output logic [XLEN-1:0]        resp_result_o,
  output logic                   resp_exc_valid_o,
  output logic [XLEN-1:0]        resp_exc_cause_o,
  output logic                   store_pending_o,
  output logic                   load_complete_o,
  output logic                   store_complete_o,
  output logic                   id_error_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned FcW  = $clog2(RespDepth + 1);

  typedef struct packed {
    logic [TransIdBits-1:0] id;
    logic [XLEN-1:0]        result;
    logic                   exc_valid;
    logic [XLEN-1:0]        exc_cause;
  } resp_t;

  logic                   stage_valid_q, stage_valid_d;
  logic [31:0]            insn_q, insn_d;
  logic [XLEN-1:0]        rs1_q, rs1_d;
  logic [XLEN-1:0]        rs2_q, rs2_d;
  logic [2:0]             frm_q, frm_d;
  logic [TransIdBits-1:0] tid_q, tid_d;
  logic [CntW-1:0]        out_cnt_q, out_cnt_d;
  logic [CntW-1:0]        store_cnt_q, store_cnt_d;
  logic                   load_cmp_q, load_cmp_d;
  logic                   store_cmp_q, store_cmp_d;
  resp_t                  mem_q [RespDepth];
  resp_t                  mem_d [RespDepth];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [FcW-1:0]         fifo_cnt_q, fifo_cnt_d;

  logic req_hs, resp_push, resp_pop, fifo_full, fifo_empty;
  logic store_inc, store_dec;
  resp_t head;

  assign fifo_full  = (fifo_cnt_q == FcW'(RespDepth));
  assign fifo_empty = (fifo_cnt_q == '0);

  assign req_ready_o      = (!stage_valid_q || acc_req_ready_i) && (out_cnt_q < CntW'(MaxOutstanding));
  assign acc_resp_ready_o = !fifo_full || resp_ready_i;
  assign req_hs           = req_valid_i && req_ready_o;
  assign resp_push        = acc_resp_valid_i && acc_resp_ready_o;
  assign resp_valid_o     = !fifo_empty;
  assign resp_pop         = resp_valid_o && resp_ready_i;

  assign store_inc = req_hs && req_is_store_i;
  assign store_dec = acc_store_done_i && (store_cnt_q != '0);

  assign acc_req_valid_o    = stage_valid_q;
  assign acc_req_insn_o     = insn_q;
  assign acc_req_rs1_o      = rs1_q;
  assign acc_req_rs2_o      = rs2_q;
  assign acc_req_frm_o      = frm_q;
  assign acc_req_trans_id_o = tid_q;

  assign head             = mem_q[rd_ptr_q];
  assign resp_trans_id_o  = head.id;
  assign resp_result_o    = head.result;
  assign resp_exc_valid_o = head.exc_valid;
  assign resp_exc_cause_o = head.exc_cause;

  assign store_pending_o  = (store_cnt_q != '0);
  assign load_complete_o  = load_cmp_q;
  assign store_complete_o = store_cmp_q;

  // Loads carry no gating role in this block.
  logic unused_is_load;
  assign unused_is_load = req_is_load_i;

  always_comb begin
    stage_valid_d = stage_valid_q;
    insn_d        = insn_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    frm_d         = frm_q;
    tid_d         = tid_q;
    if (req_hs) begin
      stage_valid_d = 1'b1;
      insn_d        = req_insn_i;
      rs1_d         = req_rs1_i;
      rs2_d         = req_rs2_i;
      frm_d         = req_frm_i;
      tid_d         = req_trans_id_i;
    end else if (acc_req_ready_i) begin
      stage_valid_d = 1'b0;
    end
  end

  // Pop decrement is guarded so a stray response cannot wrap the counter.
  always_comb begin
    out_cnt_d = out_cnt_q;
    if (req_hs && !(resp_pop && out_cnt_q != '0)) begin
      out_cnt_d = out_cnt_q + CntW'(1);
    end else if (!req_hs && resp_pop && out_cnt_q != '0) begin
      out_cnt_d = out_cnt_q - CntW'(1);
    end
    store_cnt_d = store_cnt_q;
    if (store_inc && !store_dec) begin
      store_cnt_d = store_cnt_q + CntW'(1);
    end else if (!store_inc && store_dec) begin
      store_cnt_d = store_cnt_q - CntW'(1);
    end
    load_cmp_d  = acc_load_done_i;
    store_cmp_d = acc_store_done_i;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (resp_push) begin
      mem_d[wr_ptr_q].id        = acc_resp_trans_id_i;
      mem_d[wr_ptr_q].result    = acc_resp_result_i;
      mem_d[wr_ptr_q].exc_valid = acc_resp_exc_valid_i;
      mem_d[wr_ptr_q].exc_cause = acc_resp_exc_cause_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(RespDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (resp_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(RespDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (resp_push && !resp_pop) begin
      fifo_cnt_d = fifo_cnt_q + FcW'(1);
    end else if (!resp_push && resp_pop) begin
      fifo_cnt_d = fifo_cnt_q - FcW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_valid_q <= 1'b0;
      insn_q        <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      frm_q         <= '0;
      tid_q         <= '0;
      out_cnt_q     <= '0;
      store_cnt_q   <= '0;
      load_cmp_q    <= 1'b0;
      store_cmp_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      for (int i = 0; i < int'(RespDepth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      stage_valid_q <= stage_valid_d;
      insn_q        <= insn_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      frm_q         <= frm_d;
      tid_q         <= tid_d;
      out_cnt_q     <= out_cnt_d;
      store_cnt_q   <= store_cnt_d;
      load_cmp_q    <= load_cmp_d;
      store_cmp_q   <= store_cmp_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      mem_q         <= mem_d;
    end
  end

`ifdef ACC_RESP_SHIM_ID_CHECK_EN
  localparam int unsigned NTransIds = 2 ** TransIdBits;

  logic [NTransIds-1:0] pend_q, pend_d;
  logic                 id_error_q, id_error_d;
  logic                 id_err_evt;

  assign id_err_evt = (resp_push && !pend_q[acc_resp_trans_id_i]) ||
                      (acc_store_done_i && (store_cnt_q == '0));
  assign id_error_o = id_error_q;

  // Clear before set so a same-cycle reissue of the responding ID stays tracked.
  always_comb begin
    pend_d = pend_q;
    if (resp_push) pend_d[acc_resp_trans_id_i] = 1'b0;
    if (req_hs)    pend_d[req_trans_id_i] = 1'b1;
    id_error_d = id_error_q || id_err_evt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q     <= '0;
      id_error_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      id_error_q <= id_error_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!id_err_evt) else $warning("acc_resp_shim: unmatched response ID or store_done underflow");
    end
  end
`endif
`else
  assign id_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_acc_resp_shim.sv
// tb/tb_acc_resp_shim.sv - directed self-checking bench for acc_resp_shim
module tb_acc_resp_shim;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_insn;
  logic [63:0] req_rs1, req_rs2;
  logic [2:0]  req_frm, req_tid;
  logic        req_is_load, req_is_store;
  logic        acc_req_valid, acc_req_ready;
  logic [31:0] acc_req_insn;
  logic [63:0] acc_req_rs1, acc_req_rs2;
  logic [2:0]  acc_req_frm, acc_req_tid;
  logic        acc_resp_valid, acc_resp_ready;
  logic [2:0]  acc_resp_tid;
  logic [63:0] acc_resp_result, acc_resp_cause;
  logic        acc_resp_exc;
  logic        load_done, store_done;
  logic        resp_valid, resp_ready;
  logic [2:0]  resp_tid;
  logic [63:0] resp_result, resp_cause;
  logic        resp_exc;
  logic        store_pending, load_complete, store_complete, id_error;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  acc_resp_shim dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_insn_i(req_insn),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_frm_i(req_frm),
    .req_trans_id_i(req_tid), .req_is_load_i(req_is_load), .req_is_store_i(req_is_store),
    .acc_req_valid_o(acc_req_valid), .acc_req_ready_i(acc_req_ready),
    .acc_req_insn_o(acc_req_insn), .acc_req_rs1_o(acc_req_rs1), .acc_req_rs2_o(acc_req_rs2),
    .acc_req_frm_o(acc_req_frm), .acc_req_trans_id_o(acc_req_tid),
    .acc_resp_valid_i(acc_resp_valid), .acc_resp_ready_o(acc_resp_ready),
    .acc_resp_trans_id_i(acc_resp_tid), .acc_resp_result_i(acc_resp_result),
    .acc_resp_exc_valid_i(acc_resp_exc), .acc_resp_exc_cause_i(acc_resp_cause),
    .acc_load_done_i(load_done), .acc_store_done_i(store_done),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_trans_id_o(resp_tid),
    .resp_result_o(resp_result), .resp_exc_valid_o(resp_exc), .resp_exc_cause_o(resp_cause),
    .store_pending_o(store_pending), .load_complete_o(load_complete),
    .store_complete_o(store_complete), .id_error_o(id_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 0; req_insn = 0; req_rs1 = 0; req_rs2 = 0; req_frm = 0; req_tid = 0;
    req_is_load = 0; req_is_store = 0; acc_req_ready = 1;
    acc_resp_valid = 0; acc_resp_tid = 0; acc_resp_result = 0; acc_resp_exc = 0; acc_resp_cause = 0;
    load_done = 0; store_done = 0; resp_ready = 0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    #2;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (acc_resp_ready !== 1'b1) begin n_err++; $display("FAIL reset_acc_resp_ready: got %b want 1", acc_resp_ready); end
    n_cmp++; if ({acc_req_valid, resp_valid, store_pending, load_complete, store_complete, id_error} !== 6'b0)
      begin n_err++; $display("FAIL reset_outputs: got %b want 000000", {acc_req_valid, resp_valid, store_pending, load_complete, store_complete, id_error}); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_single_store();
    do_reset();
    req_valid = 1; req_is_store = 1; req_tid = 3'd2; req_insn = 32'h0000_1234; req_frm = 3'd5;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL store_req_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 0; req_is_store = 0;
    #1;
    n_cmp++; if (acc_req_valid !== 1'b1 || acc_req_tid !== 3'd2 || acc_req_insn !== 32'h1234 || acc_req_frm !== 3'd5)
      begin n_err++; $display("FAIL store_issue: got v=%b id=%0d insn=%h frm=%0d want v=1 id=2 insn=1234 frm=5", acc_req_valid, acc_req_tid, acc_req_insn, acc_req_frm); end
    n_cmp++; if (store_pending !== 1'b1) begin n_err++; $display("FAIL store_pending_set: got %b want 1", store_pending); end
    tick(); tick(); tick(); tick();
    store_done = 1;
    #1;
    n_cmp++; if (store_complete !== 1'b0 || store_pending !== 1'b1)
      begin n_err++; $display("FAIL store_done_cycle5: got cmp=%b pend=%b want cmp=0 pend=1", store_complete, store_pending); end
    tick();
    store_done = 0;
    #1;
    n_cmp++; if (store_complete !== 1'b1 || store_pending !== 1'b0)
      begin n_err++; $display("FAIL store_done_cycle6: got cmp=%b pend=%b want cmp=1 pend=0", store_complete, store_pending); end
    tick();
    n_cmp++; if (store_complete !== 1'b0) begin n_err++; $display("FAIL store_complete_pulse: got %b want 0", store_complete); end
    load_done = 1;
    tick();
    load_done = 0;
    n_cmp++; if (load_complete !== 1'b1) begin n_err++; $display("FAIL load_complete: got %b want 1", load_complete); end
    tick();
    n_cmp++; if (load_complete !== 1'b0) begin n_err++; $display("FAIL load_complete_pulse: got %b want 0", load_complete); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    acc_req_ready = 0;
    req_valid = 1; req_tid = 3'd1; req_insn = 32'h11; req_rs1 = 64'hA1; req_rs2 = 64'hB1;
    tick();
    req_tid = 3'd2; req_insn = 32'h22; req_rs1 = 64'hA2; req_rs2 = 64'hB2;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall: got req_ready=%b want 0", req_ready); end
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (acc_req_valid !== 1'b1 || acc_req_tid !== 3'd1 || acc_req_insn !== 32'h11 || acc_req_rs1 !== 64'hA1 || acc_req_rs2 !== 64'hB1)
      begin n_err++; $display("FAIL bp_stable: got v=%b id=%0d insn=%h rs1=%h want v=1 id=1 insn=11 rs1=a1", acc_req_valid, acc_req_tid, acc_req_insn, acc_req_rs1); end
    acc_req_ready = 1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got req_ready=%b want 1", req_ready); end
    tick();
    req_valid = 0;
    #1;
    n_cmp++; if (acc_req_valid !== 1'b1 || acc_req_tid !== 3'd2 || acc_req_rs2 !== 64'hB2)
      begin n_err++; $display("FAIL bp_second_issue: got v=%b id=%0d rs2=%h want v=1 id=2 rs2=b2", acc_req_valid, acc_req_tid, acc_req_rs2); end
    tick();
    n_cmp++; if (acc_req_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", acc_req_valid); end
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      req_tid = 3'(i);
      tick();
    end
    req_tid = 3'd4;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL limit_ready: got %b want 0", req_ready); end
    tick();
    req_valid = 0;
    acc_resp_valid = 1; acc_resp_tid = 3'd0; acc_resp_result = 64'h55;
    #1;
    n_cmp++; if (acc_req_valid !== 1'b0) begin n_err++; $display("FAIL limit_no_fifth: got acc_req_valid=%b want 0", acc_req_valid); end
    tick();
    acc_resp_valid = 0; resp_ready = 1;
    #1;
    n_cmp++; if (req_ready !== 1'b0 || resp_valid !== 1'b1)
      begin n_err++; $display("FAIL limit_pop_cycle: got ready=%b rv=%b want ready=0 rv=1", req_ready, resp_valid); end
    tick();
    resp_ready = 0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL limit_reopen: got %b want 1", req_ready); end
  endtask

  task automatic test_resp_fifo();
    do_reset();
    acc_resp_valid = 1; acc_resp_tid = 3'd1; acc_resp_result = 64'hAAAA; acc_resp_exc = 1; acc_resp_cause = 64'h7;
    #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL fifo_latency: got %b want 0", resp_valid); end
    tick();
    acc_resp_tid = 3'd2; acc_resp_result = 64'hBBBB; acc_resp_exc = 0; acc_resp_cause = 64'h0;
    tick();
    acc_resp_valid = 0;
    #1;
    n_cmp++; if (acc_resp_ready !== 1'b0) begin n_err++; $display("FAIL fifo_full: got %b want 0", acc_resp_ready); end
    n_cmp++; if (resp_valid !== 1'b1 || resp_tid !== 3'd1 || resp_result !== 64'hAAAA || resp_exc !== 1'b1 || resp_cause !== 64'h7)
      begin n_err++; $display("FAIL fifo_head0: got v=%b id=%0d res=%h exc=%b want v=1 id=1 res=aaaa exc=1", resp_valid, resp_tid, resp_result, resp_exc); end
    resp_ready = 1; acc_resp_valid = 1; acc_resp_tid = 3'd3; acc_resp_result = 64'hCCCC;
    #1;
    n_cmp++; if (acc_resp_ready !== 1'b1) begin n_err++; $display("FAIL fifo_push_pop_full: got %b want 1", acc_resp_ready); end
    tick();
    acc_resp_valid = 0;
    #1;
    n_cmp++; if (resp_tid !== 3'd2 || resp_result !== 64'hBBBB || resp_exc !== 1'b0)
      begin n_err++; $display("FAIL fifo_head1: got id=%0d res=%h want id=2 res=bbbb", resp_tid, resp_result); end
    tick();
    n_cmp++; if (resp_valid !== 1'b1 || resp_tid !== 3'd3 || resp_result !== 64'hCCCC)
      begin n_err++; $display("FAIL fifo_head2: got v=%b id=%0d res=%h want v=1 id=3 res=cccc", resp_valid, resp_tid, resp_result); end
    tick();
    resp_ready = 0;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL fifo_empty: got %b want 0", resp_valid); end
  endtask

  task automatic test_store_simultaneous();
    do_reset();
    req_valid = 1; req_is_store = 1; req_tid = 3'd0;
    tick();
    req_tid = 3'd1; store_done = 1;
    tick();
    req_valid = 0; req_is_store = 0; store_done = 1;
    #1;
    n_cmp++; if (store_pending !== 1'b1) begin n_err++; $display("FAIL simul_store_cnt: got pend=%b want 1", store_pending); end
    tick();
    store_done = 0;
    #1;
    n_cmp++; if (store_pending !== 1'b0) begin n_err++; $display("FAIL simul_store_drain: got pend=%b want 0", store_pending); end
  endtask

  task automatic test_id_check();
    logic exp_err;
`ifdef ACC_RESP_SHIM_ID_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    acc_resp_valid = 1; acc_resp_tid = 3'd5; acc_resp_result = 64'h1;
    tick();
    acc_resp_valid = 0;
    n_cmp++; if (id_error !== exp_err) begin n_err++; $display("FAIL id_err_set: got %b want %b", id_error, exp_err); end
    tick(); tick();
    n_cmp++; if (id_error !== exp_err) begin n_err++; $display("FAIL id_err_sticky: got %b want %b", id_error, exp_err); end
    do_reset();
    store_done = 1;
    tick();
    store_done = 0;
    n_cmp++; if (id_error !== exp_err || store_pending !== 1'b0)
      begin n_err++; $display("FAIL store_underflow: got err=%b pend=%b want err=%b pend=0", id_error, store_pending, exp_err); end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_back_pressure();
    test_outstanding_limit();
    test_resp_fifo();
    test_store_simultaneous();
    test_id_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
